cc_compare_pipe: RTL and testbench

CC_COMPARE_PIPE -- requirements
Module: CC_COMPARE_PIPE

---
 rtl/cc_compare_pipe.sv | 155 +++++++++++++++
 tb/tb_cc_compare_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_compare_pipe.sv
// Streaming comparator with MAX/MIN burst tracking; one registered result beat per compare or per burst (latency 1).
// Backpressure: single output register, input ready while the register is free or draining; non-last tracking beats always accepted.
module cc_compare_pipe #(
  parameter int NUMBER_DATAWIDTH  = 8,
  parameter int NUMBER_COUNTWIDTH = 8
) (
  input  logic                         CC_COMPARE_PIPE_CLOCK_50,
  input  logic                         CC_COMPARE_PIPE_RESET_InHigh,
  input  logic                         CC_COMPARE_PIPE_valid_In,
  output logic                         CC_COMPARE_PIPE_ready_Out,
  input  logic [NUMBER_DATAWIDTH-1:0]  CC_COMPARE_PIPE_dataA_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0]  CC_COMPARE_PIPE_dataB_InBUS,
  input  logic [2:0]                   CC_COMPARE_PIPE_mode_InBUS,
  input  logic                         CC_COMPARE_PIPE_signed_In,
  input  logic                         CC_COMPARE_PIPE_last_In,
  output logic                         CC_COMPARE_PIPE_valid_Out,
  input  logic                         CC_COMPARE_PIPE_ready_In,
  output logic                         CC_COMPARE_PIPE_result_Out,
  output logic [2:0]                   CC_COMPARE_PIPE_flags_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0]  CC_COMPARE_PIPE_extreme_OutBUS,
  output logic [NUMBER_COUNTWIDTH-1:0] CC_COMPARE_PIPE_count_OutBUS
);

  localparam int W = NUMBER_DATAWIDTH;
  localparam int C = NUMBER_COUNTWIDTH;
  localparam logic [C-1:0] COUNT_ONE = C'(1);

  typedef enum logic {IDLE, ACCUM} state_t;
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } flags_t;

  // Sign- or zero-extend by one bit so a single signed compare covers both encodings.
  function automatic flags_t compareFlags(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic isSigned);
    logic signed [W:0] ea;
    logic signed [W:0] eb;
    flags_t f;
    ea = {isSigned & a[W-1], a};
    eb = {isSigned & b[W-1], b};
    f.gt = (ea > eb);
    f.eq = (ea == eb);
    f.lt = (ea < eb);
    return f;
  endfunction

  state_t         state, stateNext;
  logic [W-1:0]   accExtreme;
  logic [C-1:0]   accCount;
  logic           accMin, accSigned;

  logic           validQ, resultQ;
  flags_t         flagsQ;
  logic [W-1:0]   extremeQ;
  logic [C-1:0]   countQ;

  logic           ready, accept, trackBeat, trackMin, trackSigned, emit, resultD;
  flags_t         flagsBeat, flagsAcc, flagsFinal, flagsD;
  logic [W-1:0]   newExtreme, extremeD;
  logic [C-1:0]   newCount, countD;

  // A non-last beat inside a burst never produces output, so it may pass a held result.
  assign ready = !CC_COMPARE_PIPE_RESET_InHigh &&
                 ((state == ACCUM && !CC_COMPARE_PIPE_last_In) || !validQ || CC_COMPARE_PIPE_ready_In);
  assign accept = CC_COMPARE_PIPE_valid_In && ready;

  always_comb begin
    stateNext   = state;
    trackBeat   = (state == ACCUM) || (CC_COMPARE_PIPE_mode_InBUS[2:1] == 2'b11);
    trackMin    = (state == ACCUM) ? accMin    : CC_COMPARE_PIPE_mode_InBUS[0];
    trackSigned = (state == ACCUM) ? accSigned : CC_COMPARE_PIPE_signed_In;
    flagsBeat   = compareFlags(CC_COMPARE_PIPE_dataA_InBUS, CC_COMPARE_PIPE_dataB_InBUS,
                               CC_COMPARE_PIPE_signed_In);
    flagsAcc    = compareFlags(accExtreme, CC_COMPARE_PIPE_dataA_InBUS, accSigned);
    newExtreme  = CC_COMPARE_PIPE_dataA_InBUS;
    newCount    = COUNT_ONE;
    if (state == ACCUM) begin
      // Ties keep the stored extreme; the value is identical either way.
      newExtreme = accExtreme;
      if (accMin ? flagsAcc.gt : flagsAcc.lt)
        newExtreme = CC_COMPARE_PIPE_dataA_InBUS;
      newCount = (&accCount) ? accCount : accCount + COUNT_ONE;
    end
    flagsFinal = compareFlags(newExtreme, CC_COMPARE_PIPE_dataB_InBUS, trackSigned);
    emit       = accept && (!trackBeat || CC_COMPARE_PIPE_last_In);

    resultD  = 1'b0;
    flagsD   = flagsBeat;
    extremeD = CC_COMPARE_PIPE_dataA_InBUS;
    countD   = COUNT_ONE;
    if (trackBeat) begin
      resultD  = trackMin ? flagsFinal.lt : flagsFinal.gt;
      flagsD   = flagsFinal;
      extremeD = newExtreme;
      countD   = newCount;
    end else begin
      case (CC_COMPARE_PIPE_mode_InBUS)
        3'b000:  resultD = flagsBeat.gt;
        3'b001:  resultD = flagsBeat.lt;
        3'b010:  resultD = flagsBeat.eq;
        3'b011:  resultD = !flagsBeat.eq;
        3'b100:  resultD = flagsBeat.gt || flagsBeat.eq;
        3'b101:  resultD = flagsBeat.lt || flagsBeat.eq;
        default: resultD = 1'b0;
      endcase
    end

    if (accept && trackBeat)
      stateNext = CC_COMPARE_PIPE_last_In ? IDLE : ACCUM;
  end

  always_ff @(posedge CC_COMPARE_PIPE_CLOCK_50) begin
    if (CC_COMPARE_PIPE_RESET_InHigh) begin
      state      <= IDLE;
      accExtreme <= '0;
      accCount   <= '0;
      accMin     <= 1'b0;
      accSigned  <= 1'b0;
      validQ     <= 1'b0;
      resultQ    <= 1'b0;
      flagsQ     <= '0;
      extremeQ   <= '0;
      countQ     <= '0;
    end else begin
      state <= stateNext;
      if (accept && trackBeat) begin
        accExtreme <= newExtreme;
        accCount   <= newCount;
        if (state == IDLE) begin
          accMin    <= CC_COMPARE_PIPE_mode_InBUS[0];
          accSigned <= CC_COMPARE_PIPE_signed_In;
        end
      end
      if (emit) begin
        validQ   <= 1'b1;
        resultQ  <= resultD;
        flagsQ   <= flagsD;
        extremeQ <= extremeD;
        countQ   <= countD;
      end else if (CC_COMPARE_PIPE_ready_In) begin
        validQ <= 1'b0;
      end
    end
  end

  assign CC_COMPARE_PIPE_ready_Out      = ready;
  assign CC_COMPARE_PIPE_valid_Out      = validQ;
  assign CC_COMPARE_PIPE_result_Out     = resultQ;
  assign CC_COMPARE_PIPE_flags_OutBUS   = flagsQ;
  assign CC_COMPARE_PIPE_extreme_OutBUS = extremeQ;
  assign CC_COMPARE_PIPE_count_OutBUS   = countQ;

endmodule

// File: tb/tb_cc_compare_pipe.sv
// Scoreboard bench for cc_compare_pipe: directed scenarios plus randomized traffic against a list-based model.
module tb_cc_compare_pipe;
  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst, vIn, rdyOut, lastIn, sgnIn, vOut, rdyIn, resOut;
  logic [W-1:0] a, b, extOut;
  logic [2:0] mode, flagsOut;
  logic [C-1:0] cntOut;

  always #5 clk = ~clk;

  cc_compare_pipe #(.NUMBER_DATAWIDTH(W), .NUMBER_COUNTWIDTH(C)) dut (
    .CC_COMPARE_PIPE_CLOCK_50      (clk),
    .CC_COMPARE_PIPE_RESET_InHigh  (rst),
    .CC_COMPARE_PIPE_valid_In      (vIn),
    .CC_COMPARE_PIPE_ready_Out     (rdyOut),
    .CC_COMPARE_PIPE_dataA_InBUS   (a),
    .CC_COMPARE_PIPE_dataB_InBUS   (b),
    .CC_COMPARE_PIPE_mode_InBUS    (mode),
    .CC_COMPARE_PIPE_signed_In     (sgnIn),
    .CC_COMPARE_PIPE_last_In       (lastIn),
    .CC_COMPARE_PIPE_valid_Out     (vOut),
    .CC_COMPARE_PIPE_ready_In      (rdyIn),
    .CC_COMPARE_PIPE_result_Out    (resOut),
    .CC_COMPARE_PIPE_flags_OutBUS  (flagsOut),
    .CC_COMPARE_PIPE_extreme_OutBUS(extOut),
    .CC_COMPARE_PIPE_count_OutBUS  (cntOut)
  );

  typedef struct {
    logic         res;
    logic [2:0]   flags;
    logic [W-1:0] ext;
    logic [C-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int nCmp = 0;
  int nBad = 0;

  // Model state: burst membership, latched burst attributes, beats seen, pending output.
  bit inBurst = 0;
  bit bMin, bSgn;
  bit pendOut = 0;
  logic [W-1:0] bVals[$];

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int toInt(logic [W-1:0] v, bit s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  function automatic logic [2:0] flagsOf(int x, int y);
    return {x > y, x == y, x < y};
  endfunction

  // One clock of stimulus; the model decides acceptance on its own and predicts result beats.
  task automatic drive(bit r, bit v, logic [W-1:0] da, logic [W-1:0] db, logic [2:0] m,
                       bit s, bit l, bit rd);
    bit expRdy, acc, emit;
    exp_t e;
    @(posedge clk); #1;
    rst = r; vIn = v; a = da; b = db; mode = m; sgnIn = s; lastIn = l; rdyIn = rd;
    #1;
    expRdy = !r && (!pendOut || rd || (inBurst && !l));
    cmp("ready_Out", rdyOut, expRdy);
    if (r) begin
      inBurst = 0;
      pendOut = 0;
      sb.delete();
      return;
    end
    acc  = v && expRdy;
    emit = 0;
    if (acc) begin
      if (!inBurst && m[2:1] != 2'b11) begin
        int x, y;
        logic [2:0] f;
        x = toInt(da, s);
        y = toInt(db, s);
        f = flagsOf(x, y);
        case (m)
          3'd0: e.res = x > y;
          3'd1: e.res = x < y;
          3'd2: e.res = x == y;
          3'd3: e.res = x != y;
          3'd4: e.res = x >= y;
          default: e.res = x <= y;
        endcase
        e.flags = f; e.ext = da; e.cnt = 1;
        sb.push_back(e);
        emit = 1;
      end else begin
        if (!inBurst) begin
          bMin = m[0]; bSgn = s; bVals.delete(); inBurst = 1;
        end
        bVals.push_back(da);
        if (l) begin
          logic [W-1:0] ext;
          int n;
          ext = bVals[0];
          foreach (bVals[i])
            if (bMin ? toInt(bVals[i], bSgn) < toInt(ext, bSgn)
                     : toInt(bVals[i], bSgn) > toInt(ext, bSgn))
              ext = bVals[i];
          n = bVals.size();
          e.ext   = ext;
          e.cnt   = (n > 2**C - 1) ? C'(2**C - 1) : C'(n);
          e.flags = flagsOf(toInt(ext, bSgn), toInt(db, bSgn));
          e.res   = bMin ? e.flags[0] : e.flags[2];
          sb.push_back(e);
          inBurst = 0;
          emit = 1;
        end
      end
    end
    pendOut = emit || (pendOut && !rd);
  endtask

  task automatic checkOut(string name, bit v, bit res, logic [2:0] f, logic [W-1:0] ext,
                          logic [C-1:0] cnt);
    cmp({name, " valid"}, vOut, v);
    cmp({name, " result"}, resOut, res);
    cmp({name, " flags"}, flagsOut, f);
    cmp({name, " extreme"}, extOut, ext);
    cmp({name, " count"}, cntOut, cnt);
  endtask

  task automatic idleHold();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops on every output transfer, and checks held outputs stay frozen.
  initial begin
    bit held;
    logic [W+C+3:0] prev;
    exp_t e;
    held = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) held = 0;
      else begin
        if (held) begin
          cmp("hold valid_Out", vOut, 1);
          cmp("hold buses", {resOut, flagsOut, extOut, cntOut}, prev);
        end
        if (vOut && rdyIn) begin
          if (sb.size() == 0) cmp("unexpected beat", vOut, 0);
          else begin
            e = sb.pop_front();
            cmp("sb result", resOut, e.res);
            cmp("sb flags", flagsOut, e.flags);
            cmp("sb extreme", extOut, e.ext);
            cmp("sb count", cntOut, e.cnt);
          end
        end
        held = vOut && !rdyIn;
        prev = {resOut, flagsOut, extOut, cntOut};
      end
    end
  end

  initial begin
    rst = 1; vIn = 0; a = 0; b = 0; mode = 0; sgnIn = 0; lastIn = 0; rdyIn = 0;
    drive(1, 1, 8'h11, 8'h22, 3'd0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idleHold();
    checkOut("reset state", 0, 0, 3'b000, 8'h00, 4'd0);

    // GT unsigned vs signed on the same data
    drive(0, 1, 8'h80, 8'h7F, 3'b000, 0, 0, 1);
    idleHold();
    checkOut("gt unsigned", 1, 1, 3'b100, 8'h80, 4'd1);
    drive(0, 1, 8'h80, 8'h7F, 3'b000, 1, 0, 1);
    idleHold();
    checkOut("gt signed", 1, 0, 3'b001, 8'h80, 4'd1);

    // Back-to-back EQ beats at full throughput
    drive(0, 1, 8'd3, 8'd3, 3'b010, 0, 1, 1);
    drive(0, 1, 8'd4, 8'd5, 3'b010, 0, 0, 1);
    drive(0, 1, 8'd9, 8'd9, 3'b010, 1, 0, 1);
    drive(0, 1, 8'd0, 8'd255, 3'b010, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);

    // Stall: pending result held for 3 cycles while a new beat waits
    drive(0, 1, 8'd7, 8'd7, 3'b010, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'd1, 8'd2, 3'b000, 0, 0, 0);
    drive(0, 1, 8'd1, 8'd2, 3'b000, 0, 0, 1);
    idleHold();
    checkOut("after stall", 1, 0, 3'b001, 8'd1, 4'd1);

    // MAX-track unsigned
    drive(0, 1, 8'd5, 8'd0, 3'b110, 0, 0, 1);
    drive(0, 1, 8'd200, 8'd0, 3'b110, 0, 0, 1);
    drive(0, 1, 8'd17, 8'd100, 3'b110, 0, 1, 1);
    idleHold();
    checkOut("max track", 1, 1, 3'b100, 8'd200, 4'd3);

    // MIN-track signed
    drive(0, 1, 8'h05, 8'h00, 3'b111, 1, 0, 1);
    drive(0, 1, 8'hF0, 8'h00, 3'b111, 1, 0, 1);
    drive(0, 1, 8'h02, 8'h00, 3'b111, 1, 1, 1);
    idleHold();
    checkOut("min track", 1, 1, 3'b001, 8'hF0, 4'd3);

    // Mode/sign changes after the first beat must be ignored
    drive(0, 1, 8'h10, 8'h00, 3'b111, 0, 0, 1);
    drive(0, 1, 8'hF0, 8'h00, 3'b000, 1, 0, 1);
    drive(0, 1, 8'h20, 8'h15, 3'b110, 1, 1, 1);
    idleHold();
    checkOut("latched mode", 1, 1, 3'b001, 8'h10, 4'd3);

    // Count saturates at 2^C-1
    for (int i = 0; i < 18; i++) drive(0, 1, W'(i), 8'd0, 3'b110, 0, i == 17, 1);
    idleHold();
    checkOut("count sat", 1, 1, 3'b100, 8'd17, 4'd15);

    // Reset mid-burst discards it; next burst starts fresh
    drive(0, 1, 8'd50, 8'd0, 3'b110, 0, 0, 1);
    drive(0, 1, 8'd60, 8'd0, 3'b110, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idleHold();
    checkOut("reset mid burst", 0, 0, 3'b000, 8'd0, 4'd0);
    drive(0, 1, 8'd3, 8'd0, 3'b110, 0, 0, 1);
    drive(0, 1, 8'd9, 8'd9, 3'b110, 0, 1, 1);
    idleHold();
    checkOut("fresh burst", 1, 0, 3'b010, 8'd9, 4'd2);

    for (int i = 0; i < 2500; i++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, W'($urandom),
            W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
    cmp("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
